// File: rtl/rv_div_seq.sv
// Sequential restoring integer divider for RISC-V DIV/DIVU/REM/REMU.
// Covers special cases, a stall input (rdy), kill, and reuse of the last result.
module rv_div_seq #(
  parameter int XLEN     = 32,
  parameter int UNROLL   = 1,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            xreset,
  input  logic            rdy,
  input  logic            req,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rrd1,
  input  logic [XLEN-1:0] rrd2,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] rwdat
);

  localparam int NITER = XLEN / UNROLL;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] x);
    return (~x) + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? neg_val(x) : x;
  endfunction

  state_t state_r, state_s;

  logic [1:0]      op_r;
  logic [XLEN-1:0] a_r, b_r;
  logic [XLEN-1:0] quo_r, div_r;
  logic [XLEN:0]   rem_r;
  logic [CW-1:0]   cnt_r;
  logic            q_neg_r, r_neg_r;
  logic [XLEN-1:0] out_r;

  logic            cache_vld_r, cache_sgn_r;
  logic [XLEN-1:0] cache_a_r, cache_b_r, cache_quo_r, cache_rem_r;

  logic            busy_r, valid_r;
  logic [XLEN-1:0] rwdat_r;

  logic            accept_s, hit_s, sgn_op_s, rem_op_s, zero_s, ovf_s;
  logic [XLEN-1:0] spec_res_s, q_fix_s, r_fix_s, quo_t, hit_res_s;
  logic [XLEN:0]   rem_t;
  logic            busy_s, valid_s, load_s;

  // Request decode: acceptance, reuse lookup and special-case detection
  always_comb begin
    accept_s  = (state_r == S_IDLE) && req && rdy && !kill;
    hit_s     = CACHE_EN && cache_vld_r && (rrd1 == cache_a_r) && (rrd2 == cache_b_r)
                && (cache_sgn_r == !op[0]);
    hit_res_s = op[1] ? cache_rem_r : cache_quo_r;
    sgn_op_s  = !op_r[0];
    rem_op_s  = op_r[1];
    zero_s    = (b_r == ZERO);
    ovf_s     = sgn_op_s && (a_r == MIN_INT) && (b_r == ALL_ONES);
    if (zero_s) begin
      spec_res_s = rem_op_s ? a_r : ALL_ONES;
    end else begin
      spec_res_s = rem_op_s ? ZERO : a_r;
    end
  end

  // Restoring division: UNROLL quotient bits per cycle, remainder kept at XLEN+1 bits
  always_comb begin
    logic ge;
    rem_t = rem_r;
    quo_t = quo_r;
    for (int u = 0; u < UNROLL; u++) begin
      rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
      ge    = (rem_t >= {1'b0, div_r});
      rem_t = ge ? (rem_t - {1'b0, div_r}) : rem_t;
      quo_t = {quo_t[XLEN-2:0], ge};
    end
  end

  // Sign correction of the unsigned quotient and remainder
  always_comb begin
    q_fix_s = q_neg_r ? neg_val(quo_r) : quo_r;
    r_fix_s = r_neg_r ? neg_val(rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; kill overrides rdy, rdy=0 freezes the sequence
  always_comb begin
    state_s = state_r;
    if (kill && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
    end else if (!rdy) begin
      state_s = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_s = hit_s ? S_DONE : S_PREP;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_PREP: begin
          if (zero_s || ovf_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ITER;
          end
        end
        S_ITER: begin
          if (cnt_r == CW'(0)) begin
            state_s = S_FIX;
          end else begin
            state_s = S_ITER;
          end
        end
        S_FIX:   state_s = S_DONE;
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Output decode: busy follows next state, valid and data load on leaving DONE
  always_comb begin
    busy_s  = (state_s != S_IDLE);
    valid_s = valid_r;
    load_s  = 1'b0;
    if (kill && (state_r != S_IDLE)) begin
      valid_s = 1'b0;
      load_s  = 1'b0;
    end else if (rdy) begin
      valid_s = (state_r == S_DONE);
      load_s  = (state_r == S_DONE);
    end else begin
      valid_s = valid_r;
      load_s  = 1'b0;
    end
  end

  // Operand capture, iteration datapath and result reuse entry
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      op_r        <= 2'b00;
      a_r         <= ZERO;
      b_r         <= ZERO;
      quo_r       <= ZERO;
      div_r       <= ZERO;
      rem_r       <= {(XLEN+1){1'b0}};
      cnt_r       <= CW'(0);
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      out_r       <= ZERO;
      cache_vld_r <= 1'b0;
      cache_sgn_r <= 1'b0;
      cache_a_r   <= ZERO;
      cache_b_r   <= ZERO;
      cache_quo_r <= ZERO;
      cache_rem_r <= ZERO;
    end else if (kill) begin
      cache_vld_r <= 1'b0;
    end else if (rdy) begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r <= op;
            a_r  <= rrd1;
            b_r  <= rrd2;
            out_r <= hit_s ? hit_res_s : out_r;
          end else begin
            op_r <= op_r;
          end
        end
        S_PREP: begin
          quo_r   <= abs_val(a_r, sgn_op_s);
          div_r   <= abs_val(b_r, sgn_op_s);
          rem_r   <= {(XLEN+1){1'b0}};
          cnt_r   <= CW'(NITER - 1);
          q_neg_r <= sgn_op_s && (a_r[XLEN-1] ^ b_r[XLEN-1]);
          r_neg_r <= sgn_op_s && a_r[XLEN-1];
          out_r   <= spec_res_s;
        end
        S_ITER: begin
          rem_r <= rem_t;
          quo_r <= quo_t;
          if (cnt_r != CW'(0)) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_FIX: begin
          out_r       <= rem_op_s ? r_fix_s : q_fix_s;
          cache_vld_r <= CACHE_EN;
          cache_sgn_r <= sgn_op_s;
          cache_a_r   <= a_r;
          cache_b_r   <= b_r;
          cache_quo_r <= q_fix_s;
          cache_rem_r <= r_fix_s;
        end
        S_DONE:  out_r <= out_r;
        default: out_r <= out_r;
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      rwdat_r <= ZERO;
    end else begin
      busy_r  <= busy_s;
      valid_r <= valid_s;
      if (load_s) begin
        rwdat_r <= out_r;
      end else begin
        rwdat_r <= rwdat_r;
      end
    end
  end

  assign busy  = busy_r;
  assign valid = valid_r;
  assign rwdat = rwdat_r;

endmodule

// File: doc/rv_div_seq.md
RV_DIV_SEQ -- requirements
Module: rv_div_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width (even, >= 8).
REQ-002 The block SHALL have parameter UNROLL, default 1, meaning quotient bits per iteration cycle (1, 2 or 4; XLEN divisible by UNROLL).
REQ-003 The block SHALL have parameter CACHE_EN, default 1, meaning enable last-operand result reuse.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 xreset  input  1  asynchronous active-low reset.
REQ-006 rdy  input  1  pipeline enable; 0 freezes all state.
REQ-007 req  input  1  start request.
REQ-008 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 rrd1  input  XLEN  dividend.
REQ-010 rrd2  input  XLEN  divisor.
REQ-011 kill  input  1  abort in-flight operation.
REQ-012 busy  output  1  operation in flight; req ignored.
REQ-013 valid  output  1  one-cycle result strobe.
REQ-014 rwdat  output  XLEN  result, meaningful when valid=1.

Function
REQ-015 States: IDLE, PREP, ITER, FIX, DONE; all transitions only when rdy=1.
REQ-016 Accept: IDLE and req=1 and rdy=1 latches op, rrd1, rrd2; busy=1 from next cycle.
REQ-017 PREP: absolute values for signed ops, record quotient/remainder signs, detect special cases; 1 cycle.
REQ-018 ITER: restoring division, UNROLL bits/cycle, exactly XLEN/UNROLL cycles via down-counter; counter reaching 0 -> FIX.
REQ-019 FIX: negate quotient if operand signs differ (signed DIV), negate remainder if dividend negative (signed REM); 1 cycle -> DONE.
REQ-020 DONE: valid=1, rwdat driven, busy=0, then IDLE; a req in DONE cycle is not accepted (accepted next cycle earliest).
REQ-021 Normal latency accept-edge to valid: XLEN/UNROLL+3 cycles (35 for defaults), excluding rdy=0 cycles.
REQ-022 Divisor zero: PREP -> DONE directly; DIV/DIVU result all-ones, REM/REMU result = rrd1; latency 2.
REQ-023 Signed overflow (rrd1 = 2^(XLEN-1), rrd2 = all-ones, DIV/REM): PREP -> DONE; DIV result = rrd1, REM result 0; latency 2.
REQ-024 Cache: with CACHE_EN=1, block stores last completed rrd1, rrd2, signedness, quotient and remainder; accept with identical rrd1, rrd2 and signedness SHALL skip to DONE with stored value; latency 1.
REQ-025 Cache entry invalidated by reset and by kill; special-case results (REQ-022/023) not cached.
REQ-026 kill=1 in any non-IDLE state: next state IDLE, no valid, busy=0 next cycle; kill has priority over rdy and over DONE (valid suppressed same cycle).
REQ-027 kill=1 with req=1 in IDLE: request not accepted.
REQ-028 rdy=0: state, counter, partial remainder, valid and rwdat held; valid strobe stays high until a cycle with rdy=1 passes.
REQ-029 Operands on rrd1/rrd2/op after accept SHALL not affect the result.
REQ-030 Internal partial remainder width XLEN+1; no value truncation for any operand pair.

Reset
REQ-031 xreset=0 SHALL asynchronously force state IDLE, busy=0, valid=0, rwdat=0, counter 0, cache invalid.
REQ-032 Reset mid-operation SHALL discard the operation with no valid after release; first req after release accepted normally.

Verification
REQ-033 DIV rrd1=-7 (0xFFFFFFF9), rrd2=2 -> valid after 35 cycles, rwdat=0xFFFFFFFD; then REM same operands -> valid after 1 cycle, rwdat=0xFFFFFFFF.
REQ-034 DIVU rrd1=100, rrd2=0 -> valid after 2 cycles, rwdat=0xFFFFFFFF; REMU same -> rwdat=100, latency 2.
REQ-035 DIV rrd1=0x80000000, rrd2=0xFFFFFFFF -> rwdat=0x80000000; REM same -> rwdat=0, both latency 2.
REQ-036 DIVU 0xFFFFFFFF/3 with rdy low 5 cycles during ITER -> valid after 40 cycles, rwdat=0x55555555.
REQ-037 kill on cycle 10 of DIVU 50/7 -> no valid, busy=0 next cycle; reissue -> latency 35 (cache miss), rwdat=7.
REQ-038 Random sweep for UNROLL=1,2,4 and XLEN=16,32 vs C model including 0, 1, -1, min-int operands -> all results match.
